// File: rtl/riscv_fetch_pkg.sv
// ==== riscv_fetch_pkg: shared defaults for the instruction-fetch front end ====
// Rev 1.0
`default_nettype none

package riscv_fetch_pkg;

    localparam int          XLEN_RV         = 64;
    localparam int          ILEN_RV         = 32;
    localparam int          DEPTH_RV        = 4;
    localparam logic [63:0] RESET_VECTOR_RV = 64'h0;
    localparam int          PC_STEP_RV      = 4;

    // One extra bit so a counter can hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ==== fetch_queue: DEPTH-slot {pc, data, filled} buffer with allocate/fill/pop pointers ====
// Rev 1.0
`default_nettype none

module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_RV,
    parameter int ILEN  = ILEN_RV,
    parameter int DEPTH = DEPTH_RV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          alloc_i,
    input  logic [XLEN-1:0]               alloc_pc_i,
    input  logic                          fill_i,
    input  logic [ILEN-1:0]               fill_data_i,
    input  logic                          pop_ready_i,
    output logic [cnt_width(DEPTH)-1:0]   alloc_cnt_o,
    output logic [cnt_width(DEPTH)-1:0]   pend_cnt_o,
    output logic                          head_valid_o,
    output logic [ILEN-1:0]               head_data_o,
    output logic [XLEN-1:0]               head_pc_o
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [ILEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    fill_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    alloc_cnt_q;
    logic [CW-1:0]    pend_cnt_q;
    logic             w_pop;

    assign w_pop        = filled_q[head_q] && pop_ready_i;
    assign head_valid_o = filled_q[head_q];
    assign head_data_o  = data_q[head_q];
    assign head_pc_o    = pc_q[head_q];
    assign alloc_cnt_o  = alloc_cnt_q;
    assign pend_cnt_o   = pend_cnt_q;

    // Allocate, fill and pop always touch distinct slots, so all three may coexist.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
            filled_q    <= '0;
            head_q      <= '0;
            fill_q      <= '0;
            tail_q      <= '0;
            alloc_cnt_q <= '0;
            pend_cnt_q  <= '0;
        end else if (flush_i) begin
            filled_q    <= '0;
            head_q      <= '0;
            fill_q      <= '0;
            tail_q      <= '0;
            alloc_cnt_q <= '0;
            pend_cnt_q  <= '0;
        end else begin
            if (alloc_i) begin
                pc_q[tail_q]     <= alloc_pc_i;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PW'(1);
            end
            if (fill_i) begin
                data_q[fill_q]   <= fill_data_i;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (w_pop) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CW'(alloc_i) - CW'(w_pop);
            pend_cnt_q  <= pend_cnt_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ==== fetch_unit: PC register, in-order imem request issue and stale-response dropping ====
// Rev 1.0
`default_nettype none

module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_RV,
    parameter int              ILEN         = ILEN_RV,
    parameter int              DEPTH        = DEPTH_RV,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_RV),
    parameter int              PC_STEP      = PC_STEP_RV
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = cnt_width(DEPTH);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   drop_cnt_d;
    logic [CW-1:0]   w_alloc_cnt;
    logic [CW-1:0]   w_pend_cnt;
    logic [CW:0]     w_credit_used;
    logic            w_req_fire;
    logic            w_fill;

    // Responses still owed to flushed requests consume credit until they return.
    assign w_credit_used  = {1'b0, w_alloc_cnt} + {1'b0, drop_cnt_q};
    assign imem_req_valid = reset && fetch_en && !redirect_valid
                            && (w_credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_fill         = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = drop_cnt_q + w_pend_cnt - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_VECTOR;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_valid),
        .alloc_i      (w_req_fire),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (w_fill),
        .fill_data_i  (imem_rsp_data),
        .pop_ready_i  (inst_ready),
        .alloc_cnt_o  (w_alloc_cnt),
        .pend_cnt_o   (w_pend_cnt),
        .head_valid_o (inst_valid),
        .head_data_o  (inst_data),
        .head_pc_o    (inst_pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==== tb_fetch_unit: table vectors, directed corner sequences and random run against a queue model ====
// Rev 1.0
`default_nettype none

module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    logic        fetch_en32 = 1'b0;
    logic        req_valid32;
    logic [31:0] req_addr32;
    logic        inst_valid32;
    logic [31:0] inst_data32;
    logic [31:0] inst_pc32;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(32'hFFFF_FFF8)) u_dut32 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en32),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(req_valid32), .imem_req_ready(1'b1),
        .imem_req_addr(req_addr32), .imem_rsp_valid(1'b0),
        .imem_rsp_data(32'h0), .inst_valid(inst_valid32),
        .inst_ready(1'b0), .inst_data(inst_data32), .inst_pc(inst_pc32)
    );

    typedef struct { logic [63:0] pc; bit live; int due; } mreq_t;
    typedef struct { bit ir; bit rv; logic [63:0] addr; bit iv; logic [63:0] ipc; } vec_t;

    mreq_t       mq[$];     // requests issued to memory, response not yet returned
    logic [63:0] bq[$];     // live PCs whose instruction sits in the buffer, oldest first
    logic [63:0] dlog[$];   // PCs the DUT actually handed to decode
    logic [31:0] wlog[$];
    logic [63:0] model_pc;
    int          cyc, lat, vecs, fails;
    bit          exp_rv, s_pop, s_rsp, s_redir;

    function automatic logic [31:0] imem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick_pre();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem(mq[0].pc);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
    endtask

    task automatic model_check();
        exp_rv  = fetch_en && !redirect_valid && ((mq.size() + bq.size()) < DEPTH);
        s_pop   = (bq.size() > 0) && inst_ready;
        s_rsp   = imem_rsp_valid;
        s_redir = redirect_valid;
        check("req_valid", imem_req_valid, exp_rv);
        check("req_addr", imem_req_addr, model_pc);
        check("inst_valid", inst_valid, bq.size() > 0);
        if (bq.size() > 0) begin
            check("inst_pc", inst_pc, bq[0]);
            check("inst_data", inst_data, imem(bq[0]));
        end
        if (inst_valid && inst_ready && !redirect_valid) dlog.push_back(inst_pc);
    endtask

    task automatic tick_post();
        mreq_t m;
        @(posedge clk);
        if (s_redir) begin
            bq.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
            if (s_rsp) void'(mq.pop_front());
            model_pc = redirect_pc;
        end else begin
            if (s_pop) void'(bq.pop_front());
            if (s_rsp) begin
                m = mq.pop_front();
                if (m.live) bq.push_back(m.pc);
            end
            if (exp_rv && imem_req_ready) begin
                mq.push_back('{pc: model_pc, live: 1'b1, due: cyc + lat});
                model_pc = model_pc + 64'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick_pre();
            model_check();
            tick_post();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst.req_valid", imem_req_valid, 1'b0);
        check("rst.req_addr", imem_req_addr, 64'h0);
        check("rst.inst_valid", inst_valid, 1'b0);
        check("rst.inst_data", inst_data, 64'h0);
        check("rst.inst_pc", inst_pc, 64'h0);
        check("rst.addr32", req_addr32, 64'hFFFF_FFF8);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete(); bq.delete(); dlog.delete();
        model_pc = 64'h0;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        bit   saw_bad;
        tbl[0] = '{ir: 0, rv: 1, addr: 64'h00, iv: 0, ipc: 64'h0};
        tbl[1] = '{ir: 0, rv: 1, addr: 64'h04, iv: 0, ipc: 64'h0};
        tbl[2] = '{ir: 0, rv: 1, addr: 64'h08, iv: 1, ipc: 64'h0};
        tbl[3] = '{ir: 0, rv: 1, addr: 64'h0C, iv: 1, ipc: 64'h0};
        tbl[4] = '{ir: 0, rv: 0, addr: 64'h10, iv: 1, ipc: 64'h0};
        tbl[5] = '{ir: 1, rv: 0, addr: 64'h10, iv: 1, ipc: 64'h0};
        tbl[6] = '{ir: 0, rv: 1, addr: 64'h10, iv: 1, ipc: 64'h4};
        tbl[7] = '{ir: 0, rv: 0, addr: 64'h14, iv: 1, ipc: 64'h4};
        vecs = 0; fails = 0; lat = 1;
        @(negedge clk);

        // Reset with fetch_en high, then wrap-around on the 32-bit instance.
        do_reset();
        fetch_en = 1'b0;
        fetch_en32 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_pre();
            if (req_valid32) wlog.push_back(req_addr32);
            model_check();
            tick_post();
        end
        fetch_en32 = 1'b0;
        check("wrap.count", wlog.size(), 4);
        if (wlog.size() >= 3) begin
            check("wrap.addr0", wlog[0], 64'hFFFF_FFF8);
            check("wrap.addr1", wlog[1], 64'hFFFF_FFFC);
            check("wrap.addr2", wlog[2], 64'h0000_0000);
        end

        // Sequential stream, latency 1, decode always ready.
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        tick(12);
        check("seq.count", dlog.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < dlog.size(); i++)
            check($sformatf("seq.pc%0d", i), dlog[i], 64'(i * 4));

        // Table: fill to DEPTH with decode stalled, one pop frees one credit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            inst_ready = tbl[i].ir;
            tick_pre();
            model_check();
            check($sformatf("tbl%0d.req_valid", i), imem_req_valid, tbl[i].rv);
            check($sformatf("tbl%0d.req_addr", i), imem_req_addr, tbl[i].addr);
            check($sformatf("tbl%0d.inst_valid", i), inst_valid, tbl[i].iv);
            if (tbl[i].iv) check($sformatf("tbl%0d.inst_pc", i), inst_pc, tbl[i].ipc);
            tick_post();
        end

        // Redirect with 0x8 and 0xC in flight at latency 3.
        do_reset();
        lat = 3; inst_ready = 1'b1; fetch_en = 1'b1;
        tick(2);
        fetch_en = 1'b0; tick(6);
        fetch_en = 1'b1; tick(2);
        fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick(1);
        redirect_valid = 1'b0; fetch_en = 1'b1;
        tick(14);
        check("redir.count", dlog.size() >= 4, 1'b1);
        if (dlog.size() >= 4) begin
            check("redir.pc0", dlog[0], 64'h0);
            check("redir.pc1", dlog[1], 64'h4);
            check("redir.pc2", dlog[2], 64'h100);
            check("redir.pc3", dlog[3], 64'h104);
        end
        saw_bad = 1'b0;
        foreach (dlog[i]) if (dlog[i] == 64'h8 || dlog[i] == 64'hC) saw_bad = 1'b1;
        check("redir.no_stale", saw_bad, 1'b0);

        // Redirect in the same cycle as a response and a pop.
        do_reset();
        lat = 2; inst_ready = 1'b1; fetch_en = 1'b1;
        tick(4);
        for (int k = 0; k < 10; k++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && bq.size() > 0) break;
            tick(1);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        tick_pre();
        check("redir2.rsp_and_pop", imem_rsp_valid && inst_valid, 1'b1);
        model_check();
        tick_post();
        redirect_valid = 1'b0;
        dlog.delete();
        tick(12);
        check("redir2.count", dlog.size() >= 2, 1'b1);
        if (dlog.size() >= 2) begin
            check("redir2.pc0", dlog[0], 64'h2000);
            check("redir2.pc1", dlog[1], 64'h2004);
        end

        // Request stall holds 0x8, then asynchronous reset mid-stall.
        do_reset();
        lat = 1; inst_ready = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1;
        tick(2);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick_pre();
            check($sformatf("stall%0d.req_valid", k), imem_req_valid, 1'b1);
            check($sformatf("stall%0d.req_addr", k), imem_req_addr, 64'h8);
            model_check();
            tick_post();
        end
        #2;
        reset = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("arst.req_valid", imem_req_valid, 1'b0);
        check("arst.req_addr", imem_req_addr, 64'h0);
        check("arst.inst_valid", inst_valid, 1'b0);
        check("arst.inst_data", inst_data, 64'h0);
        check("arst.inst_pc", inst_pc, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        mq.delete(); bq.delete(); dlog.delete();
        model_pc = 64'h0; cyc = 0;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        tick(8);
        check("arst.restart", dlog.size() > 0 && dlog[0] == 64'h0, 1'b1);

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 3000 && fails < 100; k++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                         : ({$urandom, $urandom} & ~64'h3);
            lat            = $urandom_range(1, 4);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RISC-V core.
- Holds the PC register with reset vector, sequential increment and branch/jump redirect.
- Issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions, each paired with its PC, in a DEPTH-entry queue that the decode stage drains by valid/ready; stale in-flight responses after a redirect are discarded.

Parameters:
XLEN, 64, PC/address width
ILEN, 32, instruction width
DEPTH, 4, queue entries = maximum allocated (outstanding + buffered) fetches; power of 2, >= 2
RESET_VECTOR, 64'h0, PC value after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_en  in  1  permits new requests; does not affect responses or drain
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (= fetch_pc)
imem_rsp_valid  in  1  response valid; responses return in request order, any latency >= 1 cycle
imem_rsp_data  in  ILEN  response instruction
inst_valid  out  1  head entry holds an instruction
inst_ready  in  1  decode accepts the head
inst_data  out  ILEN  head instruction
inst_pc  out  XLEN  PC of the head instruction

Behaviour:
- State:
  - fetch_pc.
  - Queue of DEPTH slots {pc, data, filled}.
  - Pointers: head (pop), fill (next slot to fill), tail (next slot to allocate).
  - alloc_cnt (0..DEPTH).
  - drop_cnt (0..DEPTH).
  - Counter widths are clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_VECTOR; pointers, alloc_cnt and drop_cnt = 0; all slots cleared to 0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_VECTOR, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-operation discards all in-flight state; any response arriving after reset release is a protocol violation and is not checked.
- Issue:
  - imem_req_valid = reset && fetch_en && !redirect_valid && (alloc_cnt + drop_cnt < DEPTH).
  - On fire (valid && ready): slot[tail].pc=fetch_pc, filled=0; tail++, alloc_cnt++; fetch_pc += PC_STEP, modulo 2^XLEN (wraps silently).
  - Once asserted, imem_req_valid and imem_req_addr stay stable until fire. The only exceptions are redirect_valid, or fetch_en falling; both may withdraw the request.
- Response:
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: slot[fill].data=imem_rsp_data, filled=1, fill++.
  - A response with no allocated unfilled slot and drop_cnt=0 is illegal (bench assertion).
- Drain:
  - inst_valid = slot[head].filled; inst_data and inst_pc come from slot[head] (registered state, no combinational path from imem_rsp_*).
  - Pop on inst_valid && inst_ready: clear filled, head++, alloc_cnt--.
- Fill latency: response in cycle N gives inst_valid in cycle N+1.
- Simultaneous issue, fill and pop in one cycle are all legal; alloc_cnt nets +1/-1.
- Full: alloc_cnt + drop_cnt = DEPTH blocks issue; a pop in the same cycle frees credit only from the next cycle.
- Redirect (priority over everything):
  - fetch_pc <= redirect_pc; all slots invalidated; pointers and alloc_cnt <= 0.
  - drop_cnt <= drop_cnt + (allocated unfilled count) - imem_rsp_valid. A response arriving in the redirect cycle is itself discarded.
  - A pop in the same cycle is discarded. No request fires in the redirect cycle.
  - The first request at redirect_pc goes out the following cycle, subject to credit.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.

Decomposition:
- Package riscv_fetch_pkg: default XLEN, ILEN and RESET_VECTOR constants; PC_STEP_RV=4.
- Sub-module fetch_queue: slot array, head/fill/tail pointers, alloc_cnt, flush input.
- fetch_unit keeps fetch_pc, issue logic and drop_cnt.

Test Plan:
- Reset then fetch_en=1, ready=1, memory latency 1, inst_ready=1 -> addresses 0x0, 0x4, 0x8 ...; inst_pc follows the same sequence, and inst_data equals the memory contents at each inst_pc.
- inst_ready=0, DEPTH=4 -> exactly 4 requests fire (0x0..0xC), then imem_req_valid=0. Raising inst_ready for 1 cycle -> one pop; 0x10 is requested the cycle after.
- Redirect to 0x100 with 2 requests outstanding (latency 3) -> both responses are discarded; inst_pc next shows 0x100 then 0x104; no 0x8/0xC entries appear.
- Redirect in the same cycle as an imem_rsp_valid and an inst_ready pop -> the response and the pop are discarded; drop_cnt equals outstanding-1; the next delivered inst_pc is redirect_pc.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid and imem_req_addr stay stable at 0x8. Reset asserted mid-stall -> outputs return to their reset values asynchronously, and fetch restarts at RESET_VECTOR.
- XLEN=32, RESET_VECTOR=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
